kbd_scan_decoder: RTL and testbench

- Sequences the byte stream from the PS/2 bit receiver (8-bit byte plus one-cycle new-byte strobe) into key events.
- Strips PS/2 set-2 prefixes: E0 (extended), F0 (break), E1 (pause).
- Filters typematic repeats and keeps a pressed/released level for the game control keys.
- Sits between the keyboard receiver and the game-control logic.

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_key_tracker.sv | 26 ++
 rtl/kbd_scan_decoder.sv | 90 +++++++++
 tb/tb_kbd_scan_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: decoder states, PS/2 set-2 byte constants and the tracked control-key table
package kbd_pkg;
  typedef enum logic [2:0] {IDLE_ST, EXT_ST, BRK_ST, EXT_BRK_ST, SKIP_ST} state_t;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_BAT = 8'hAA;
  localparam logic [7:0] RSP_ECHO = 8'hEE;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  localparam int TABLE_KEYS = 4;
  localparam logic [8:0] KEY_TABLE [TABLE_KEYS] = '{9'h16B, 9'h174, 9'h175, 9'h029};
  function automatic logic is_prefix(input logic [7:0] b);
    return b == PFX_EXT || b == PFX_BRK || b == PFX_PAUSE;
  endfunction
  function automatic logic is_response(input logic [7:0] b);
    return b == RSP_ACK || b == RSP_BAT || b == RSP_ECHO || b == RSP_RESEND || b == 8'h00 || b == 8'hFF;
  endfunction
endpackage

// File: rtl/kbd_key_tracker.sv
// kbd_key_tracker: matches events against the key table, holds pressed levels, flags first presses
module kbd_key_tracker import kbd_pkg::*; #(
  parameter int NUM_KEYS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ev_make,
  input  logic                ev_break,
  input  logic [8:0]          ev_code,
  output logic                key_first,
  output logic [NUM_KEYS-1:0] keys_down
);
  logic [NUM_KEYS-1:0] hit;
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) hit[i] = ev_code == KEY_TABLE[i];
  end
  always_ff @(posedge clk)
    if (reset) begin
      keys_down <= '0;
      key_first <= 1'b0;
    end else begin
      key_first <= ev_make && |(hit & ~keys_down);
      keys_down <= ev_make ? keys_down | hit : ev_break ? keys_down & ~hit : keys_down;
    end
endmodule

// File: rtl/kbd_scan_decoder.sv
// kbd_scan_decoder: turns PS/2 set-2 bytes into make/break key events with prefix stripping and timeout
module kbd_scan_decoder import kbd_pkg::*; #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int NUM_KEYS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          din,
  input  logic                din_new,
  output logic [8:0]          key_code,
  output logic                key_make,
  output logic                key_break,
  output logic                key_first,
  output logic [NUM_KEYS-1:0] keys_down,
  output logic                seq_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  state_t st, st_n, st_idle;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0] skip, skip_n;
  logic mk, bk, err, pfx;
  logic [8:0] code;
  always_comb begin
    pfx = is_prefix(din);
    st_idle = din == PFX_EXT ? EXT_ST : din == PFX_BRK ? BRK_ST : din == PFX_PAUSE ? SKIP_ST : IDLE_ST;
    st_n = st;
    skip_n = skip;
    mk = 1'b0;
    bk = 1'b0;
    err = 1'b0;
    code = {1'b0, din};
    tmr_n = (din_new || st == IDLE_ST) ? '0 : tmr == TMAX ? tmr : tmr + 1'b1;
    if (din_new)
      case (st)
        IDLE_ST: begin
          st_n = st_idle;
          mk = !pfx && !is_response(din);
        end
        EXT_ST: begin
          st_n = din == PFX_BRK ? EXT_BRK_ST : din == PFX_EXT ? EXT_ST : IDLE_ST;
          mk = din != PFX_BRK && din != PFX_EXT && din != FAKE_SHIFT;
          code = {1'b1, din};
        end
        BRK_ST, EXT_BRK_ST: begin
          err = pfx;
          st_n = pfx ? st_idle : IDLE_ST;
          bk = !pfx && !(st == EXT_BRK_ST && din == FAKE_SHIFT);
          code = {st == EXT_BRK_ST, din};
        end
        SKIP_ST: begin
          skip_n = skip - 1'b1;
          st_n = skip == 3'd1 ? IDLE_ST : SKIP_ST;
        end
        default: st_n = IDLE_ST;
      endcase
    else if (st != IDLE_ST && tmr == TMAX) begin
      err = 1'b1;
      st_n = IDLE_ST;
    end
    skip_n = (st_n == SKIP_ST && st != SKIP_ST) ? PAUSE_SKIP : skip_n;
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE_ST;
      tmr <= '0;
      skip <= '0;
      key_code <= '0;
      key_make <= 1'b0;
      key_break <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      skip <= skip_n;
      key_make <= mk;
      key_break <= bk;
      seq_err <= err;
      if (mk || bk) key_code <= code;
    end
  kbd_key_tracker #(.NUM_KEYS(NUM_KEYS)) u_tracker (
    .clk(clk),
    .reset(reset),
    .ev_make(mk),
    .ev_break(bk),
    .ev_code(code),
    .key_first(key_first),
    .keys_down(keys_down)
  );
endmodule

// File: tb/tb_kbd_scan_decoder.sv
// tb_kbd_scan_decoder: directed scenarios plus randomized byte streams against a flag-level reference model
module tb_kbd_scan_decoder;
  localparam int TO = 64;
  localparam logic [8:0] TBL [4] = '{9'h16B, 9'h174, 9'h175, 9'h029};
  logic clk = 1'b0, reset = 1'b1, din_new = 1'b0;
  logic [7:0] din = 8'h00;
  logic [8:0] key_code;
  logic key_make, key_break, key_first, seq_err;
  logic [3:0] keys_down;
  logic [16:0] obs, exp;
  int errors = 0, checks = 0;
  bit m_ext, m_brk;
  int m_skip;
  logic [3:0] m_keys;
  logic [8:0] m_code;
  assign obs = {key_make, key_break, key_first, seq_err, keys_down, key_code};
  always #5 clk = ~clk;
  kbd_scan_decoder #(.TIMEOUT_CYC(TO), .NUM_KEYS(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_new(din_new), .key_code(key_code),
    .key_make(key_make), .key_break(key_break), .key_first(key_first),
    .keys_down(keys_down), .seq_err(seq_err)
  );
  task automatic send(input logic [7:0] b);
    din = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
  endtask
  task automatic model_byte(input logic [7:0] b, output logic mk, output logic bk, output logic fst, output logic er);
    logic [8:0] ev;
    mk = 0; bk = 0; fst = 0; er = 0; ev = '0;
    if (m_skip > 0) m_skip--;
    else begin
      if (m_brk && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) begin er = 1; m_brk = 0; m_ext = 0; end
      if (m_brk) begin
        if (!(m_ext && b == 8'h12)) begin bk = 1; ev = {m_ext, b}; end
        m_brk = 0; m_ext = 0;
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0) begin
          if (b != 8'h12) begin mk = 1; ev = {1'b1, b}; end
          m_ext = 0;
        end
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin mk = 1; ev = {1'b0, b}; end
    end
    if (mk || bk) begin
      m_code = ev;
      for (int i = 0; i < 4; i++)
        if (ev == TBL[i]) begin
          if (mk) fst = !m_keys[i];
          m_keys[i] = mk;
        end
    end
  endtask
  task automatic test_reset;
    exp = '0;
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset: got %h want %h", obs, exp); end
  endtask
  task automatic test_plain_make;
    send(8'h1C);
    exp = {4'b1000, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL plain_make: got %h want %h", obs, exp); end
    @(negedge clk);
    exp = {4'b0000, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL make_pulse_len: got %h want %h", obs, exp); end
  endtask
  task automatic test_extended;
    send(8'hE0); send(8'h6B);
    exp = {4'b1010, 4'b0001, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL ext_make: got %h want %h", obs, exp); end
    send(8'hE0); send(8'hF0);
    exp = {4'b0000, 4'b0001, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL ext_prefix_quiet: got %h want %h", obs, exp); end
    send(8'h6B);
    exp = {4'b0100, 4'b0000, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL ext_break: got %h want %h", obs, exp); end
  endtask
  task automatic test_typematic;
    for (int n = 0; n < 3; n++) begin
      send(8'h29);
      exp = {1'b1, 1'b0, n == 0, 1'b0, 4'b1000, 9'h029};
      checks++; if (obs !== exp) begin errors++; $display("FAIL typematic_%0d: got %h want %h", n, obs, exp); end
    end
    send(8'hF0); send(8'h29);
    exp = {4'b0100, 4'b0000, 9'h029};
    checks++; if (obs !== exp) begin errors++; $display("FAIL typematic_release: got %h want %h", obs, exp); end
  endtask
  task automatic test_pause;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int n = 0; n < 8; n++) begin
      send(seq[n]);
      exp = {4'b0000, 4'b0000, 9'h029};
      checks++; if (obs !== exp) begin errors++; $display("FAIL pause_byte_%0d: got %h want %h", n, obs, exp); end
    end
    send(8'h1C);
    exp = {4'b1000, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL after_pause: got %h want %h", obs, exp); end
  endtask
  task automatic test_malformed;
    send(8'hE0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h12);
    exp = {4'b0000, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL fake_shift: got %h want %h", obs, exp); end
    send(8'hF0); send(8'hE0);
    exp = {4'b0001, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL break_then_prefix: got %h want %h", obs, exp); end
    send(8'h6B);
    exp = {4'b1010, 4'b0001, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reinterpreted_ext: got %h want %h", obs, exp); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    exp = {4'b0100, 4'b0000, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL malformed_cleanup: got %h want %h", obs, exp); end
  endtask
  task automatic test_timeout;
    int c = 0;
    send(8'hF0);
    while (c < 4 * TO && seq_err !== 1'b1) begin @(negedge clk); c++; end
    checks++; if (c !== TO) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", c, TO); end
    exp = {4'b0001, 4'b0000, 9'h16B};
    checks++; if (obs !== exp) begin errors++; $display("FAIL timeout_outputs: got %h want %h", obs, exp); end
    send(8'h1C);
    exp = {4'b1000, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL after_timeout: got %h want %h", obs, exp); end
  endtask
  task automatic test_expiry_collision;
    send(8'hF0);
    repeat (TO - 1) @(negedge clk);
    send(8'h1C);
    exp = {4'b0100, 4'b0000, 9'h01C};
    checks++; if (obs !== exp) begin errors++; $display("FAIL expiry_collision: got %h want %h", obs, exp); end
  endtask
  task automatic test_reset_mid;
    send(8'h29); send(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp = '0;
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_mid_clear: got %h want %h", obs, exp); end
    send(8'h74);
    exp = {4'b1000, 4'b0000, 9'h074};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_mid_make: got %h want %h", obs, exp); end
    din = 8'h1C; din_new = 1'b1; reset = 1'b1;
    @(negedge clk);
    din_new = 1'b0; reset = 1'b0;
    exp = '0;
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_priority: got %h want %h", obs, exp); end
  endtask
  task automatic test_random;
    logic mk, bk, fst, er;
    logic [7:0] b;
    int unsigned r;
    m_ext = 0; m_brk = 0; m_skip = 0; m_keys = '0; m_code = '0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2: b = 8'hE0;
        3, 4, 5: b = 8'hF0;
        6: b = 8'hE1;
        7: b = 8'h12;
        8, 9, 10, 11, 12: b = TBL[$urandom_range(0, 3)][7:0];
        13: b = $urandom_range(0, 1) ? 8'hFA : 8'hAA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      model_byte(b, mk, bk, fst, er);
      send(b);
      exp = {mk, bk, fst, er, m_keys, m_code};
      checks++; if (obs !== exp) begin errors++; $display("FAIL random_byte_%0d din=%h: got %h want %h", n, b, obs, exp); end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        exp = {4'b0000, m_keys, m_code};
        checks++; if (obs !== exp) begin errors++; $display("FAIL random_gap_%0d: got %h want %h", n, obs, exp); end
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_plain_make;
    test_extended;
    test_typematic;
    test_pause;
    test_malformed;
    test_timeout;
    test_expiry_collision;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
